// File: rtl/exu_agu_split.sv
// Execute-stage address generation unit: base+imm, then a load/store FSM on a
// valid/ready data bus, optionally splitting misaligned accesses into two word beats.
module exu_agu_split #(
  parameter int unsigned AW          = 32,
  parameter bit          MISAL_SPLIT = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_val,
  output logic          o_rdy,
  input  logic          i_ld,
  input  logic          i_st,
  input  logic [1:0]    i_size,
  input  logic          i_unsigned,
  input  logic [AW-1:0] i_base,
  input  logic [AW-1:0] i_imm,
  input  logic [31:0]   i_wdat,
  output logic          o_bus_val,
  input  logic          i_bus_rdy,
  output logic [AW-1:0] o_bus_adr,
  output logic          o_bus_ren,
  output logic [3:0]    o_bus_wen,
  output logic [31:0]   o_bus_wdat,
  input  logic          i_bus_rvld,
  input  logic [31:0]   i_bus_rdat,
  output logic          o_done,
  output logic [31:0]   o_res,
  output logic          o_misal
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ0, S_RSP0, S_REQ1, S_RSP1, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] adr_q;
  logic          ld_q, st_q, uns_q;
  logic [1:0]    size_q;
  logic [31:0]   wdat_q, lo_q, hi_q, res_q;
  logic          misal_q;

  // Request-side decode, evaluated on the incoming operands
  logic [AW-1:0] adr_in;
  logic [1:0]    size_in;
  logic          misal_in, accept, noop_in;

  assign adr_in   = i_base + i_imm;
  assign size_in  = (i_size == 2'd3) ? 2'd2 : i_size;
  assign misal_in = ((size_in == 2'd1) && (adr_in[1:0] == 2'd3)) ||
                    ((size_in == 2'd2) && (adr_in[1:0] != 2'd0));
  assign accept   = (state_q == S_IDLE) && i_val;
  assign noop_in  = !i_ld && !i_st;

  // Registered-access decode
  logic [1:0]    off;
  logic [4:0]    sh_amt;
  logic          two_beat;
  logic [3:0]    bytemask;
  logic [7:0]    wen64;
  logic [63:0]   wdat64;
  logic [AW-1:0] a0, a1;

  assign off      = adr_q[1:0];
  assign sh_amt   = {off, 3'b000};
  assign two_beat = ((size_q == 2'd1) && (off == 2'd3)) ||
                    ((size_q == 2'd2) && (off != 2'd0));
  assign bytemask = (size_q == 2'd0) ? 4'b0001 :
                    (size_q == 2'd1) ? 4'b0011 : 4'b1111;
  assign wen64    = {4'b0000, bytemask} << off;
  assign wdat64   = {32'b0, wdat_q} << sh_amt;
  assign a0       = {adr_q[AW-1:2], 2'b00};
  assign a1       = a0 + AW'(4);

  // Bus outputs are pure functions of registered state, so they hold under backpressure
  logic beat1;
  assign beat1      = (state_q == S_REQ1);
  assign o_bus_val  = (state_q == S_REQ0) || beat1;
  assign o_bus_adr  = o_bus_val ? (beat1 ? a1 : a0) : '0;
  assign o_bus_ren  = o_bus_val && ld_q;
  assign o_bus_wen  = (o_bus_val && st_q) ? (beat1 ? wen64[7:4] : wen64[3:0]) : 4'b0000;
  assign o_bus_wdat = (o_bus_val && st_q) ? (beat1 ? wdat64[63:32] : wdat64[31:0]) : '0;
  assign o_rdy      = (state_q == S_IDLE);
  assign o_done     = (state_q == S_DONE);
  assign o_res      = res_q;
  assign o_misal    = misal_q;

  logic        bus_acc;
  logic [31:0] lo_d, hi_d, raw, res_ext;
  logic [63:0] lohi;

  assign bus_acc = o_bus_val && i_bus_rdy;
  assign lo_d    = ((state_q == S_RSP0) && i_bus_rvld) ? i_bus_rdat : lo_q;
  assign hi_d    = ((state_q == S_RSP1) && i_bus_rvld) ? i_bus_rdat : hi_q;
  assign lohi    = {hi_d, lo_d} >> sh_amt;
  assign raw     = lohi[31:0];

  always_comb begin
    case (size_q)
      2'd0:    res_ext = uns_q ? {24'b0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      2'd1:    res_ext = uns_q ? {16'b0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: res_ext = raw;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:
        if (i_val) begin
          if (noop_in || (misal_in && (MISAL_SPLIT == 1'b0))) state_d = S_DONE;
          else                                                 state_d = S_REQ0;
        end
      S_REQ0:
        if (bus_acc) begin
          if (ld_q)          state_d = S_RSP0;
          else if (two_beat) state_d = S_REQ1;
          else               state_d = S_DONE;
        end
      S_RSP0:
        if (i_bus_rvld) state_d = two_beat ? S_REQ1 : S_DONE;
      S_REQ1:
        if (bus_acc) state_d = ld_q ? S_RSP1 : S_DONE;
      S_RSP1:
        if (i_bus_rvld) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      adr_q   <= '0;
      ld_q    <= 1'b0;
      st_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= '0;
      wdat_q  <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      res_q   <= '0;
      misal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      if (accept) begin
        adr_q  <= adr_in;
        ld_q   <= i_ld;
        st_q   <= i_st;
        uns_q  <= i_unsigned;
        size_q <= size_in;
        wdat_q <= i_wdat;
        hi_q   <= '0;
      end
      // misal_q/res_q are only ever set on the transition into DONE, so they clear on exit
      misal_q <= accept && !noop_in && misal_in && (MISAL_SPLIT == 1'b0);
      res_q   <= ((state_d == S_DONE) &&
                  ((state_q == S_RSP0) || (state_q == S_RSP1))) ? res_ext : '0;
    end
  end

endmodule

// File: doc/exu_agu_split.md
# exu_agu_split

Parametrised successor to the execute-stage address generation unit. Computes `base + imm`, then runs a multi-cycle load/store FSM against a valid/ready data bus with one outstanding access. When `MISAL_SPLIT=1` it splits misaligned half/word accesses into two aligned word transactions and merges the results; otherwise it raises a misalignment exception without touching the bus. Sits between the EXU dispatch and the data-memory/bus bridge.

## Interface
- `AW`, 32: address width (≥3); address arithmetic wraps modulo 2^AW.
- `MISAL_SPLIT`, 1: 1 = split misaligned accesses in hardware; 0 = report `o_misal`.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `i_val` in 1: request valid from EXU.
- `o_rdy` out 1: ready for a request; high only in IDLE.
- `i_ld` in 1: load request.
- `i_st` in 1: store request. At most one of `i_ld`/`i_st` is high; both low is a no-op that completes.
- `i_size` in 2: 0 byte, 1 half, 2 word; 3 is treated as word.
- `i_unsigned` in 1: zero-extend load result (LBU/LHU).
- `i_base` in AW: rs1 operand.
- `i_imm` in AW: sign-extended immediate.
- `i_wdat` in 32: store data, right-aligned.
- `o_bus_val` out 1: bus request valid.
- `i_bus_rdy` in 1: bus accepts the request when `o_bus_val & i_bus_rdy`.
- `o_bus_adr` out AW: word-aligned address; bits [1:0] are always 0.
- `o_bus_ren` out 1: read request.
- `o_bus_wen` out 4: byte-lane write enables; 0 on reads.
- `o_bus_wdat` out 32: lane-aligned write data.
- `i_bus_rvld` in 1: read response valid. Never asserted in the same cycle as the read's acceptance.
- `i_bus_rdat` in 32: read response data.
- `o_done` out 1: one-cycle completion pulse.
- `o_res` out 32: extended load result, valid with `o_done`; 0 for stores, no-ops and exceptions.
- `o_misal` out 1: misalignment exception, valid with `o_done`; only when `MISAL_SPLIT=0`.

## Operation
- **Accept.** A request is accepted on `i_val & o_rdy`. On acceptance the unit registers `adr = i_base + i_imm` (AW bits, carry dropped), `off = adr[1:0]`, op, size, unsigned flag and wdat.
- **Misaligned.** An access is misaligned when: half with `off=3`; or word with `off≠0`.
  - Such an access needs two beats. Beat 0 goes to `A0 = {adr[AW-1:2],2'b0}` and covers lanes `off..3`. Beat 1 goes to `A1 = A0+4` (wraps) and covers lanes `0..off+bytes-5`.
- **Store data.** Form the 64-bit value `{32'b0, wdat} << 8*off`. Beat 0 drives bits [31:0], beat 1 drives bits [63:32]. Lane enables are `(bytemask << off)` split the same way.
  - Bytemask: byte 4'b0001, half 4'b0011, word 4'b1111.
- **Load data.** Capture beat-0 `rdat` as `lo` and beat-1 `rdat` as `hi` (`hi=0` when there is no beat 1). Take `raw = ({hi,lo} >> 8*off)[31:0]`. Mask to the access size, then sign- or zero-extend per `i_unsigned`.
- **FSM states:** IDLE, REQ0, RSP0, REQ1, RSP1, DONE.
  - IDLE → DONE on accept of a no-op, or of a misaligned access when `MISAL_SPLIT=0` (sets `misal_q`). Otherwise IDLE → REQ0.
  - REQ0: `o_bus_val=1`. On acceptance:
    - load → RSP0;
    - store needing two beats → REQ1;
    - store otherwise → DONE.
  - RSP0: on `i_bus_rvld`, capture `lo`; go to REQ1 if two beats are needed, else DONE.
  - REQ1: `o_bus_val=1`. On acceptance a load goes to RSP1, a store goes to DONE.
  - RSP1: on `i_bus_rvld`, capture `hi` → DONE.
  - DONE: `o_done=1` for one cycle, then → IDLE.
- **Stores** need no response; they complete on bus acceptance. `i_bus_rvld` outside RSP0/RSP1 is ignored.
- **Bus outputs are held stable** while `o_bus_val` is high and `i_bus_rdy` is low.

## Timing
- **Reset values:** state IDLE, `o_rdy=1`, `o_bus_val=0`, `o_bus_ren=0`, `o_bus_wen=0`, `o_bus_adr=0`, `o_bus_wdat=0`, `o_done=0`, `o_res=0`, `o_misal=0`.
- **Reset mid-operation** returns the unit to IDLE immediately. Any in-flight bus response is then ignored.
- **Aligned load, zero-wait bus** (`i_bus_rdy=1`, `rvld` one cycle after acceptance):
  - accept at cycle 0;
  - bus request cycle 1;
  - `rvld` cycle 2;
  - `o_done` cycle 3.
  - Latency is 3 cycles.
- **Aligned store:** `o_done` at cycle 2.
- **Split load:** `o_done` at cycle 5. **Split store:** `o_done` at cycle 3.
- **Exception or no-op:** `o_done` at cycle 1, with no bus activity.
- **Throughput:** `o_rdy` is low from the cycle after acceptance until the cycle after `o_done`. A new request can therefore be accepted in the cycle after `o_done`.
- **Registered outputs:** `o_res` and `o_misal` are registered and are 0 whenever `o_done=0`.

## Test plan
- **Aligned LW:** base=0x100, imm=4, bus returns 0xDEADBEEF → one read at 0x104; `o_done` at cycle 3 with `o_res=0xDEADBEEF`.
- **LB/LBU:** base=0x103, imm=0, rdat=0x80000000 → LB gives `o_res=0xFFFFFF80`; LBU gives `0x00000080`.
- **Split LW** (`MISAL_SPLIT=1`): adr=0x202, beat0 at 0x200 returns 0xAABBCCDD, beat1 at 0x204 returns 0x11223344 → `o_res=0x3344AABB`.
- **Split SH:** adr=0x3FF, wdat=0x0000BEEF → beat 0 at 0x3FC with wen=4'b1000, wdat=0xEF000000; beat 1 at 0x400 with wen=4'b0001, wdat=0x000000BE.
- **`MISAL_SPLIT=0`, LH** at 0x3 → no `o_bus_val`; `o_done=1`, `o_misal=1`, `o_res=0` at cycle 1.
- **Backpressure, wrap and reset:**
  - Hold `i_bus_rdy=0` for 5 cycles → address and data stay stable.
  - Split word at adr=2^AW−2 → beat 1 goes to address 0.
  - Assert `rst_n=0` while in RSP0 → all outputs are at reset values; a late `rvld` is ignored.
